// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter between edge-capture blocks and the PacoBlaze interrupt handshake.
// Define INTERRUPT_ARBITER_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module interrupt_arbiter #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] int_req,
    input  logic [N_SRC-1:0] int_mask,
    output logic [N_SRC-1:0] int_ack,
    output logic             cpu_interrupt,
    input  logic             cpu_interrupt_ack,
    input  logic             eoi,
    output logic [ID_W-1:0]  int_id,
    output logic             int_active,
    output logic [N_SRC-1:0] int_pending
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]       state;
    logic [N_SRC-1:0] eligible;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  sel;
    logic [N_SRC-1:0] sel_onehot;
    logic             grant;

    function automatic logic [ID_W-1:0] pick_lowest(input logic [N_SRC-1:0] v);
        logic [ID_W-1:0] w;
        w = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) w = ID_W'(i);
        end
        return w;
    endfunction

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
        return (int'(i) == N_SRC - 1) ? '0 : i + 1'b1;
    endfunction

    assign eligible      = int_req & int_mask;
    assign int_pending   = eligible;
    assign cpu_interrupt = (state == REQ);
    assign int_active    = (state == SERVICE);
    assign grant         = (state == REQ) && cpu_interrupt_ack;
    assign sel_onehot    = {{(N_SRC-1){1'b0}}, 1'b1} << sel;

`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr;

    // Rotate so the pointer lands on bit 0, pick the lowest, then rotate the index back.
    function automatic logic [ID_W-1:0] pick_rotated(input logic [N_SRC-1:0] v,
                                                     input logic [ID_W-1:0]  p);
        logic [N_SRC-1:0] rot;
        logic [ID_W-1:0]  off;
        logic [ID_W:0]    sum;
        rot = N_SRC'({v, v} >> p);
        off = pick_lowest(rot);
        sum = {1'b0, p} + {1'b0, off};
        if (sum >= (ID_W+1)'(N_SRC)) sum = sum - (ID_W+1)'(N_SRC);
        return sum[ID_W-1:0];
    endfunction

    assign winner = pick_rotated(eligible, ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= next_idx(sel);
        end
    end
`else
    assign winner = pick_lowest(eligible);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            int_ack <= '0;
            int_id  <= '0;
        end else begin
            int_ack <= '0;
            case (state)
                IDLE: begin
                    if (|eligible) state <= REQ;
                end
                REQ: begin
                    if (cpu_interrupt_ack) begin
                        state   <= SERVICE;
                        int_ack <= sel_onehot;
                        int_id  <= sel;
                    end
                end
                SERVICE: begin
                    if (eoi) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sel is only consumed in REQ, where it is always freshly latched from IDLE.
    always_ff @(posedge clk) begin
        if (state == IDLE && |eligible) sel <= winner;
    end

endmodule
